// File: rtl/game_pkg.sv
// Shared game definitions: state encoding driven by state_machine, score width
// and the saturating point increment used by the score registers.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_SCORED = 2'd2,
    ST_OVER   = 2'd3
  } game_state_t;

  localparam int SCORE_W = 3;

  // Add one point, holding at lim once it has been reached.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] value,
                                                 input logic [SCORE_W-1:0] lim);
    return (value >= lim) ? lim : value + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Start-button conditioner: two-flop synchronizer, stability counter and a
// combinational rise strobe. The strobe is high during the cycle whose closing
// edge accepts a new high level, so the parent can register it and act on the
// same edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             accept;

  // The counter measures how long sync2 has disagreed with the accepted level;
  // the new value is taken once it has disagreed for DEBOUNCE_CYCLES cycles.
  assign differ = (sync2 != level);
  assign accept = differ && (cnt == CNT_W'(DEBOUNCE_CYCLES));
  assign rise   = accept && sync2;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Stability counter and accepted (debounced) level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (!differ) begin
      cnt <= '0;
    end else if (accept) begin
      cnt   <= '0;
      level <= sync2;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Feeder for the game state machine: debounced start pulse, goal edge
// detection with a post-point holdoff window, and saturating per-player
// point counters. Every output is a flop.
module score_keeper
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLDOFF_CYCLES  = 1024,
  parameter int MAX_SCORE       = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_start,
  input  logic               goal_p1,
  input  logic               goal_p2,
  input  logic [1:0]         cur_state,
  output logic               start,
  output logic               score,
  output logic [SCORE_W-1:0] p1,
  output logic [SCORE_W-1:0] p2
);

  localparam int                HOLD_W    = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(MAX_SCORE);

  logic              start_rise;
  logic              goal_p1_q;
  logic              goal_p2_q;
  logic [HOLD_W-1:0] holdoff;
  logic              armed;
  logic              acc_p1;
  logic              acc_p2;
  logic              clear;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn_start),
    .rise (start_rise)
  );

  // A goal edge counts only during play and outside the holdoff window;
  // anything rejected here is simply dropped, never remembered for later.
  assign armed  = (cur_state == ST_PLAY) && (holdoff == '0);
  assign acc_p1 = goal_p1 && !goal_p1_q && armed;
  assign acc_p2 = goal_p2 && !goal_p2_q && armed;
  // A start press outside a running game begins a fresh match.
  assign clear  = start_rise && ((cur_state == ST_IDLE) || (cur_state == ST_OVER));

  // One-cycle goal history for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      goal_p1_q <= 1'b0;
      goal_p2_q <= 1'b0;
    end else begin
      goal_p1_q <= goal_p1;
      goal_p2_q <= goal_p2;
    end
  end

  // Holdoff reloads on every accepted point and drains to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      holdoff <= '0;
    end else if (acc_p1 || acc_p2) begin
      holdoff <= HOLD_W'(HOLDOFF_CYCLES);
    end else if (holdoff != '0) begin
      holdoff <= holdoff - HOLD_W'(1);
    end
  end

  // Output pulses and score registers; a clear overrides a same-cycle point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start <= 1'b0;
      score <= 1'b0;
      p1    <= '0;
      p2    <= '0;
    end else begin
      start <= start_rise;
      score <= acc_p1 || acc_p2;
      if (clear) begin
        p1 <= '0;
        p2 <= '0;
      end else begin
        if (acc_p1) p1 <= sat_inc(p1, SCORE_MAX);
        if (acc_p2) p2 <= sat_inc(p2, SCORE_MAX);
      end
    end
  end

endmodule
